// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full_adder is reused once per cycle, LSB first.
// The result is valid during the single-cycle done pulse and is held until the next accepted start.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             c_out_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_reg[cnt_reg]),
    .b  (b_reg[cnt_reg]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // Only the bit addressed by the counter takes the adder output; all other bits hold.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum_bit
      assign sum_next[gi] = (state_reg == RUN && cnt_reg == CW'(gi)) ? fa_s : sum_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      sum_reg <= sum_next;
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= c_in;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          carry_reg <= fa_co;
          // The counter stops at the last bit rather than wrapping back to zero.
          if (cnt_reg == LAST) begin
            c_out_reg <= fa_co;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign sum   = sum_reg;
  assign c_out = c_out_reg;
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: a WIDTH=8 and a WIDTH=4 instance checked every cycle against a
// timeline model (cycles since acceptance, arithmetic result), plus literal expectations.

module tb_serial_add_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s[2];
  logic [7:0] a_s[2];
  logic [7:0] b_s[2];
  logic       cin_s[2];

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .c_in(cin_s[0]),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1][3:0]), .b(b_s[1][3:0]), .c_in(cin_s[1]),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
  );

  int cmp_count = 0;
  int err_count = 0;
  bit checking  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic busy_v(input int i);
    return (i == 0) ? busy8 : busy4;
  endfunction
  function automatic logic done_v(input int i);
    return (i == 0) ? done8 : done4;
  endfunction
  function automatic logic [7:0] sum_v(input int i);
    return (i == 0) ? sum8 : {4'b0000, sum4};
  endfunction
  function automatic logic cout_v(input int i);
    return (i == 0) ? cout8 : cout4;
  endfunction

  // Model: age = cycles since the accepting edge (-1 when idle); held = last completed result.
  int         wid[2]  = '{8, 4};
  int         age[2]  = '{-1, -1};
  logic [8:0] pend[2] = '{9'd0, 9'd0};
  logic [8:0] held[2] = '{9'd0, 9'd0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        age[i]  = -1;
        held[i] = '0;
      end else if (age[i] < 0) begin
        if (start_s[i]) begin
          age[i] = 1;
          if (i == 0) pend[i] = 9'(a_s[0]) + 9'(b_s[0]) + 9'(cin_s[0]);
          else        pend[i] = 9'(a_s[1][3:0]) + 9'(b_s[1][3:0]) + 9'(cin_s[1]);
        end
      end else begin
        age[i] = age[i] + 1;
        if (age[i] == wid[i] + 1) held[i] = pend[i];
        else if (age[i] > wid[i] + 1) age[i] = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        logic       eb, ed;
        logic [7:0] es;
        eb = (age[i] >= 1) && (age[i] <= wid[i]);
        ed = (age[i] == wid[i] + 1);
        es = (i == 0) ? held[i][7:0] : {4'b0000, held[i][3:0]};
        check($sformatf("model busy w%0d", wid[i]), 32'(busy_v(i)), 32'(eb));
        check($sformatf("model done w%0d", wid[i]), 32'(done_v(i)), 32'(ed));
        if (!eb) begin
          check($sformatf("model sum w%0d", wid[i]), 32'(sum_v(i)), 32'(es));
          check($sformatf("model c_out w%0d", wid[i]), 32'(cout_v(i)), 32'(held[i][wid[i]]));
        end
      end
    end
  end

  // Waits (bounded) for done; n counts negedges since the start was accepted.
  task automatic wait_done(input int i, input logic [8:0] exp, output int n);
    bit seen;
    seen = 1'b0;
    n    = 1;
    while (!seen && n <= wid[i] + 4) begin
      if (done_v(i)) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      n = -1;
      check($sformatf("done timeout w%0d", wid[i]), 32'(0), 32'(1));
    end else begin
      check($sformatf("sum w%0d", wid[i]), 32'(sum_v(i)), (i == 0) ? 32'(exp[7:0]) : 32'(exp[3:0]));
      check($sformatf("c_out w%0d", wid[i]), 32'(cout_v(i)), 32'(exp[wid[i]]));
    end
  endtask

  task automatic op(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic [8:0] exp);
    int n;
    a_s[i]     = a;
    b_s[i]     = b;
    cin_s[i]   = cin;
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    wait_done(i, exp, n);
    check($sformatf("latency w%0d", wid[i]), 32'(n), 32'(wid[i] + 1));
    $display("op w%0d a=0x%0h b=0x%0h cin=%0d -> sum=0x%0h c_out=%0d latency=%0d",
             wid[i], a, b, cin, sum_v(i), cout_v(i), n);
    @(negedge clk);
  endtask

  initial begin
    int         n;
    int         pulses;
    logic [7:0] ra, rb;
    logic       rc;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      a_s[i]     = '0;
      b_s[i]     = '0;
      cin_s[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("reset busy", 32'(busy8), 32'(0));
    check("reset done", 32'(done8), 32'(0));
    check("reset sum", 32'(sum8), 32'(0));
    check("reset c_out", 32'(cout8), 32'(0));
    rst = 1'b0;

    // Hand-computed results.
    op(0, 8'h5A, 8'h3C, 1'b0, 9'h096);
    op(0, 8'hFF, 8'h01, 1'b0, 9'h100);
    op(0, 8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // start held high with operands churning during RUN/DONE.
    a_s[0] = 8'h12; b_s[0] = 8'h34; cin_s[0] = 1'b0; start_s[0] = 1'b1;
    pulses = 0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (done8) begin
        pulses++;
        check("held-start sum", 32'(sum8), 32'h46);
      end
      if (j == 11) check("held-start restart busy", 32'(busy8), 32'(1));
      if (j == 10) begin
        a_s[0] = 8'h20; b_s[0] = 8'h03; cin_s[0] = 1'b0;
      end else begin
        a_s[0] = 8'($urandom); b_s[0] = 8'($urandom); cin_s[0] = 1'($urandom);
      end
    end
    check("held-start done pulses", 32'(pulses), 32'(1));
    start_s[0] = 1'b0;
    wait_done(0, 9'h023, n);
    $display("op w8 restarted under held start -> sum=0x%0h c_out=%0d", sum8, cout8);
    @(negedge clk);

    // Reset during the 4th RUN cycle abandons the operation.
    a_s[0] = 8'h77; b_s[0] = 8'h11; cin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-run reset busy", 32'(busy8), 32'(0));
    check("mid-run reset done", 32'(done8), 32'(0));
    check("mid-run reset sum", 32'(sum8), 32'(0));
    check("mid-run reset c_out", 32'(cout8), 32'(0));
    $display("reset during RUN -> busy=%0d done=%0d sum=0x%0h", busy8, done8, sum8);
    op(0, 8'h01, 8'h01, 1'b0, 9'h002);

    // rst and start on the same edge.
    rst = 1'b1; start_s[0] = 1'b1; a_s[0] = 8'h0F; b_s[0] = 8'h0F;
    @(negedge clk);
    rst = 1'b0; start_s[0] = 1'b0;
    check("rst+start busy", 32'(busy8), 32'(0));
    @(negedge clk);
    check("rst+start no op", 32'(busy8), 32'(0));
    $display("rst with start -> busy=%0d sum=0x%0h", busy8, sum8);

    repeat (40) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op(0, ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
    end

    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      v = 9'(k);
      op(1, {4'b0000, v[3:0]}, {4'b0000, v[7:4]}, v[8],
         9'(v[3:0]) + 9'(v[7:4]) + 9'(v[8]));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
